// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and helpers: default widths, NZP condition-code
// encoding and the flag computation reused by the ALU/PSR logic.
package lc3_pkg;

  localparam int LC3_DATA_W   = 16;
  localparam int LC3_NUM_REGS = 8;

  // {N,Z,P}; exactly one bit is set at any time.
  typedef logic [2:0] cc_t;

  localparam cc_t CC_Z = 3'b010;

  function automatic cc_t calc_nzp(input logic [LC3_DATA_W-1:0] data);
    logic neg;
    logic zero;
    neg  = data[LC3_DATA_W-1];
    zero = (data == '0);
    return {neg, zero, !neg && !zero};
  endfunction

endpackage

// File: rtl/lc3_scoreboard.sv
// Busy scoreboard for in-flight destination registers: tracks which registers
// have a pending producer, gates new allocations and keeps a running count.
module lc3_scoreboard #(
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en,
  input  logic [ADDR_W-1:0]   alloc_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                flush,
  output logic                alloc_ready,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [ADDR_W:0]     pend_cnt
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                alloc_take;
  logic                cnt_inc;
  logic                cnt_dec;

  // A same-cycle writeback frees the slot, so a busy target can be re-allocated.
  assign alloc_ready = !flush && (!busy_q[alloc_addr] || (wr_en && wr_addr == alloc_addr));
  assign alloc_take  = alloc_en && alloc_ready;

  // A writeback only decrements when its clear is not overridden by a new producer.
  assign cnt_inc = alloc_take && !busy_q[alloc_addr];
  assign cnt_dec = wr_en && busy_q[wr_addr] && !(alloc_take && alloc_addr == wr_addr);

  // NOTE: combinational next-state uses blocking '=' with a full default first,
  // so no path leaves busy_d unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)      busy_d[wr_addr]    = 1'b0;
    if (alloc_take) busy_d[alloc_addr] = 1'b1;
    if (flush)      busy_d             = '0;
  end

  always_comb begin
    cnt_d = cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
    if (flush) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 general-purpose register file with write-to-read bypass, a busy
// scoreboard for pending destinations and the NZP condition-code register.
module lc3_regfile_sb
  import lc3_pkg::*;
#(
  parameter  int DATA_W   = LC3_DATA_W,
  parameter  int NUM_REGS = LC3_NUM_REGS,
  parameter  int NUM_RD   = 3,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     cc_ld,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_ready,
  input  logic                     flush,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [ADDR_W:0]          pend_cnt,
  output logic [2:0]               cc
);

  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  cc_t                   cc_q;
  logic [LC3_DATA_W-1:0] nzp_word;

  // NOTE: the array is architecturally visible after reset, so it sits in
  // flops with an explicit async clear rather than in an unreset RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Fold any DATA_W onto the shared helper: keeps sign and non-zero-ness,
  // which is all NZP depends on.
  assign nzp_word = {wr_data[DATA_W-1], {(LC3_DATA_W-2){1'b0}}, |wr_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cc_q <= CC_Z;
    else if (wr_en && cc_ld) cc_q <= calc_nzp(nzp_word);
  end

  assign cc = cc_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit  = wr_en && (wr_addr == addr);
    assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs_q[addr];
    assign rd_busy[k] = busy_vec[addr] && !hit;
  end

  lc3_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .flush       (flush),
    .alloc_ready (alloc_ready),
    .busy_vec    (busy_vec),
    .pend_cnt    (pend_cnt)
  );

endmodule
